// File: rtl/dmem_bytelane_if.sv
// Request/response bundle for the byte-lane data memory.
// The master drives requests and the memory (slave) returns load data and status.
interface dmem_bytelane_if;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        ready;
    logic        misalign;

    modport master (
        output addr, data_in, MemWrite, MemRead, size, ld_unsigned,
        input  data_out, rd_valid, ready, misalign
    );

    modport slave (
        input  addr, data_in, MemWrite, MemRead, size, ld_unsigned,
        output data_out, rd_valid, ready, misalign
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressable 32-bit data memory with sub-word loads/stores, one-cycle
// registered load latency, misalignment rejection and an optional post-reset zero sweep.
module dmem_bytelane #(
    parameter int DEPTH_LOG2     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_bytelane_if.slave    bus
);
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state_reg, state_next;
    logic [DEPTH_LOG2-1:0]   clr_cnt_reg, clr_cnt_next;

    logic                    ready;
    logic                    clearing;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [1:0]              req_off;
    logic                    req_mis;
    logic                    accept;
    logic                    ld_go;
    logic                    st_go;
    logic                    mis_go;

    logic [3:0]              st_be;
    logic [31:0]             st_lanes;
    logic [3:0]              wr_be;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [31:0]             wr_data;

    logic [31:0]             rd_word;
    logic [1:0]              ld_off_reg;
    logic [1:0]              ld_size_reg;
    logic                    ld_uns_reg;
    logic                    rd_valid_reg;
    logic                    misalign_reg;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [31:0]             load_value;

    // Address bits above the word index are deliberately ignored (aliasing).
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:DEPTH_LOG2+2];

    assign ready    = (state_reg == IDLE);
    assign clearing = (state_reg == CLEAR) && !reset;
    assign req_idx  = bus.addr[DEPTH_LOG2+1:2];
    assign req_off  = bus.addr[1:0];

    always_comb begin
        req_mis = 1'b0;
        case (bus.size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = bus.addr[0];
            2'b10:   req_mis = |bus.addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    assign accept = ready && !reset && (bus.MemRead || bus.MemWrite);
    assign ld_go  = accept && !req_mis && bus.MemRead;
    assign st_go  = accept && !req_mis && bus.MemWrite;
    assign mis_go = accept && req_mis;

    // Store data is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = {4{bus.data_in[7:0]}};
        case (bus.size)
            2'b00:   st_be = 4'b0001 << req_off;
            2'b01: begin
                st_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{bus.data_in[15:0]}};
            end
            2'b10: begin
                st_be    = 4'b1111;
                st_lanes = bus.data_in;
            end
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_idx  = req_idx;
        wr_data = st_lanes;
        if (clearing) begin
            wr_be   = 4'b1111;
            wr_idx  = clr_cnt_reg;
            wr_data = 32'h0000_0000;
        end else if (st_go) begin
            wr_be   = st_be;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == '1) begin
                    state_next = IDLE;
                end
            end
            IDLE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // One RAM per byte lane; the read register samples before the write lands,
    // which gives read-first behaviour for a simultaneous load and store.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [2**DEPTH_LOG2];
        logic [7:0] rd_reg;

        always_ff @(posedge clk) begin
            if (wr_be[gi]) begin
                mem[wr_idx] <= wr_data[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_reg <= 8'h00;
            end else if (ld_go) begin
                rd_reg <= mem[req_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_off_reg   <= 2'b00;
            ld_size_reg  <= 2'b10;
            ld_uns_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            rd_valid_reg <= ld_go;
            misalign_reg <= mis_go;
            if (ld_go) begin
                ld_off_reg  <= req_off;
                ld_size_reg <= bus.size;
                ld_uns_reg  <= bus.ld_unsigned;
            end
        end
    end

    // Extraction works on the held read word, so data_out holds between loads.
    always_comb begin
        ld_byte = rd_word[7:0];
        case (ld_off_reg)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = ld_off_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_size_reg)
            2'b00:   load_value = {{24{!ld_uns_reg && ld_byte[7]}}, ld_byte};
            2'b01:   load_value = {{16{!ld_uns_reg && ld_half[15]}}, ld_half};
            default: load_value = rd_word;
        endcase
    end

    assign bus.data_out = load_value;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.ready    = ready;
    assign bus.misalign = misalign_reg;
endmodule
